// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake and an
// optional approximate mode that cuts carries into the lowest block boundaries.
module pipelined_cla_adder #(
   parameter int unsigned WIDTH         = 16,
   parameter int unsigned BLOCK         = 4,
   parameter int unsigned APPROX_BLOCKS = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic                     cin,
   input  logic                     approx_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         sum,
   output logic                     cout,
   output logic [WIDTH/BLOCK-1:0]   blk_p,
   output logic [WIDTH/BLOCK-1:0]   blk_g
);

   localparam int unsigned N = WIDTH / BLOCK;

   logic             rdy_q;
   logic             s1_valid_q, s2_valid_q;
   logic             s1_adv, s2_adv, accept;

   logic [WIDTH-1:0] p_d, g_d, p_q, g_q;
   logic [N-1:0]     bp_d, bg_d, bp_q, bg_q;
   logic             cin_q, apx_q;

   logic [N:0]       c;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_q;
   logic [N-1:0]     blk_p_q, blk_g_q;

   assign s2_adv    = !s2_valid_q || out_ready;
   assign s1_adv    = !s1_valid_q || s2_adv;
   assign in_ready  = rdy_q && s1_adv;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign blk_p     = blk_p_q;
   assign blk_g     = blk_g_q;

   // Stage 1: bit and group propagate/generate.
   always_comb begin
      logic gp, gg;
      p_d  = a ^ b;
      g_d  = a & b;
      bp_d = '0;
      bg_d = '0;
      for (int unsigned k = 0; k < N; k++) begin
         gp = 1'b1;
         gg = 1'b0;
         for (int unsigned i = 0; i < BLOCK; i++) begin
            gg = g_d[k*BLOCK+i] | (p_d[k*BLOCK+i] & gg);
            gp = gp & p_d[k*BLOCK+i];
         end
         bp_d[k] = gp;
         bg_d[k] = gg;
      end
   end

   // Stage 2 block carries as flat sum-of-products. In approx mode the product
   // terms reaching below the cut are dropped, which equals substituting the
   // forced-zero carry at boundary APPROX_BLOCKS.
   always_comb begin
      logic acc, prod, cut;
      c    = '0;
      c[0] = cin_q;
      cut  = apx_q && (APPROX_BLOCKS > 0);
      for (int unsigned k = 0; k < N; k++) begin
         acc = 1'b0;
         if (!cut) begin
            prod = cin_q;
            for (int unsigned m = 0; m <= k; m++) prod = prod & bp_q[m];
            acc = acc | prod;
         end
         for (int unsigned j = 0; j <= k; j++) begin
            if (!cut || j >= APPROX_BLOCKS) begin
               prod = bg_q[j];
               for (int unsigned m = j + 1; m <= k; m++) prod = prod & bp_q[m];
               acc = acc | prod;
            end
         end
         c[k+1] = (cut && (k + 1 <= APPROX_BLOCKS)) ? 1'b0 : acc;
      end
   end

   // In-block carries, flat from the block carry-in.
   always_comb begin
      logic acc, prod;
      sum_d = '0;
      for (int unsigned k = 0; k < N; k++) begin
         for (int unsigned i = 0; i < BLOCK; i++) begin
            acc = c[k];
            for (int unsigned m = 0; m < i; m++) acc = acc & p_q[k*BLOCK+m];
            for (int unsigned j = 0; j < i; j++) begin
               prod = g_q[k*BLOCK+j];
               for (int unsigned m = j + 1; m < i; m++) prod = prod & p_q[k*BLOCK+m];
               acc = acc | prod;
            end
            sum_d[k*BLOCK+i] = p_q[k*BLOCK+i] ^ acc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q      <= 1'b0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         p_q        <= '0;
         g_q        <= '0;
         bp_q       <= '0;
         bg_q       <= '0;
         cin_q      <= 1'b0;
         apx_q      <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         blk_p_q    <= '0;
         blk_g_q    <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (s1_adv) begin
            s1_valid_q <= accept;
            if (accept) begin
               p_q   <= p_d;
               g_q   <= g_d;
               bp_q  <= bp_d;
               bg_q  <= bg_d;
               cin_q <= cin;
               apx_q <= approx_en;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               sum_q   <= sum_d;
               cout_q  <= c[N];
               blk_p_q <= bp_q;
               blk_g_q <= bg_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: a per-block ripple model predicts
// each accepted beat; results are popped in order as the DUT hands them off.
module tb_pipelined_cla_adder;

   localparam int unsigned W = 16;
   localparam int unsigned B = 4;
   localparam int unsigned N = W / B;
   localparam int unsigned A = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         approx_en = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic [N-1:0] blk_p, blk_g;

   pipelined_cla_adder #(.WIDTH(W), .BLOCK(B), .APPROX_BLOCKS(A)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .approx_en(approx_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .blk_p(blk_p), .blk_g(blk_g)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic [N-1:0] bp;
      logic [N-1:0] bg;
   } exp_t;

   exp_t q[$];
   exp_t e, last;
   int   n_cmp = 0, n_err = 0;
   int   pops = 0, run = 0, maxrun = 0, cyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic ci, input logic ap);
      exp_t         r;
      logic         carry;
      logic [B-1:0] ab, bb;
      logic [B:0]   t, tg;
      r = '0;
      carry = ci;
      for (int unsigned k = 0; k < N; k++) begin
         if (ap && k >= 1 && k <= A) carry = 1'b0;
         ab = av[k*B +: B];
         bb = bv[k*B +: B];
         t  = {1'b0, ab} + {1'b0, bb} + {{B{1'b0}}, carry};
         tg = {1'b0, ab} + {1'b0, bb};
         r.sum[k*B +: B] = t[B-1:0];
         carry   = t[B];
         r.bp[k] = &(ab ^ bb);
         r.bg[k] = tg[B];
      end
      r.cout = carry;
      return r;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         q.delete();
         run = 0;
      end else begin
         if (out_valid && out_ready) begin
            run++;
            if (run > maxrun) maxrun = run;
            pops++;
            if (q.size() == 0) begin
               check("unexpected_out", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               check("sum", 64'(sum), 64'(e.sum));
               check("cout", 64'(cout), 64'(e.cout));
               check("blk_p", 64'(blk_p), 64'(e.bp));
               check("blk_g", 64'(blk_g), 64'(e.bg));
               last = {sum, cout, blk_p, blk_g};
            end
         end else begin
            run = 0;
         end
         if (in_valid && in_ready) q.push_back(model(a, b, cin, approx_en));
      end
   end

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic ap);
      a = av; b = bv; cin = ci; approx_en = ap; in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            return;
         end
      end
      check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (q.size() == 0 && !out_valid) break;
         @(posedge clk); #1;
      end
      check("drain", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0, c0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_blk_p", 64'(blk_p), 64'd0);
      check("rst_blk_g", 64'(blk_g), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_rst", 64'(in_ready), 64'd1);

      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      drain();
      check("wrap_sum", 64'(last.sum), 64'h0000);
      check("wrap_cout", 64'(last.cout), 64'd1);
      check("wrap_blk_p", 64'(last.bp), 64'hE);
      check("wrap_blk_g", 64'(last.bg), 64'h1);

      send(16'h7FFF, 16'h0000, 1'b1, 1'b0);
      drain();
      check("cin_sum", 64'(last.sum), 64'h8000);
      check("cin_cout", 64'(last.cout), 64'd0);
      check("cin_blk_p", 64'(last.bp), 64'h7);
      check("cin_blk_g", 64'(last.bg), 64'h0);

      send(16'h000F, 16'h0001, 1'b0, 1'b1);
      drain();
      check("approx_sum", 64'(last.sum), 64'h0000);
      check("approx_cout", 64'(last.cout), 64'd0);
      send(16'h000F, 16'h0001, 1'b0, 1'b0);
      drain();
      check("exact_sum", 64'(last.sum), 64'h0010);

      out_ready = 1'b0;
      p0 = pops;
      send(16'd1, 16'd1, 1'b0, 1'b0);
      send(16'd2, 16'd2, 1'b0, 1'b0);
      a = 16'd3; b = 16'd3; in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_hold", 64'(sum), 64'h0002);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(16'd3, 16'd3, 1'b0, 1'b0);
      send(16'd4, 16'd4, 1'b0, 1'b0);
      drain();
      check("bp_count", 64'(pops - p0), 64'd4);
      check("bp_last", 64'(last.sum), 64'h0008);

      out_ready = 1'b1;
      maxrun = 0;
      c0 = cyc;
      for (int i = 0; i < 8; i++)
         send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      check("tput_cycles", 64'(cyc - c0), 64'd8);
      drain();
      check("tput_run", 64'(maxrun), 64'd8);

      out_ready = 1'b0;
      send(16'd10, 16'd20, 1'b0, 1'b0);
      send(16'd30, 16'd40, 1'b1, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_sum", 64'(sum), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      p0 = pops;
      @(posedge clk); #1;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      repeat (5) begin
         @(negedge clk);
         check("midrst_no_stale", 64'(out_valid), 64'd0);
      end
      check("midrst_pops", 64'(pops - p0), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
